paint_packet_decoder: RTL
=========================

# paint_packet_decoder

Assembles the byte stream from the SPI receiver into complete paint commands (brush flag, 3-bit colour code, pixel X/Y) for the pixel store. Sits between the SPI byte receiver and `pixelStore` in the 25.175 MHz pixel-clock domain. Emits one-cycle `ready` strobes with registered, held outputs. Drops malformed, out-of-range or stalled packets and counts them.

## Interface
- `H_ACTIVE`, 640, X values ≥ this are rejected.
- `V_ACTIVE`, 480, Y values ≥ this are rejected.
- `TIMEOUT_CYCLES`, 25175, maximum idle gap between bytes of one packet (1 ms at 25.175 MHz).
- `clk` in 1: pixel clock, single clock domain.
- `reset` in 1: synchronous, active-low.
- `byte_valid` in 1: `byte_data` holds a new received byte this cycle.
- `byte_data` in 8: received SPI byte.
- `x` out 10: pixel column of the last accepted packet.
- `y` out 10: pixel row of the last accepted packet.
- `brush` out 1: 1 = paint, 0 = erase/none.
- `newColor` out 3: colour code.
- `ready` out 1: one-cycle strobe, new x/y/brush/newColor valid.
- `err_cnt` out 8: saturating count of dropped packets/bytes.

## Operation
- Packet, MSB first:
  - B0 = {4'hA sync, brush, color[2:0]}
  - B1 = {6'b0, x[9:8]}
  - B2 = x[7:0]
  - B3 = {6'b0, y[9:8]}
  - B4 = y[7:0]
  - B5 = checksum (macro only).
- FSM states: HDR → XH → XL → YH → YL → (CK) → HDR.
  - Advance only on a cycle with `byte_valid` = 1.
- In HDR, a byte with upper nibble ≠ 4'hA is discarded.
  - `err_cnt` +1; FSM stays in HDR. This gives resynchronisation.
- Fields are collected in shadow registers. Outputs update only on a good final byte.
- Packet is dropped at its final byte (outputs untouched, no `ready`, `err_cnt` +1, return to HDR) if any of:
  - reserved bits in B1/B3 ≠ 0;
  - x ≥ `H_ACTIVE`;
  - y ≥ `V_ACTIVE`;
  - checksum mismatch.
- Gap timer:
  - Clears on every accepted byte.
  - Counts while FSM ≠ HDR.
  - On reaching `TIMEOUT_CYCLES`: abort to HDR, `err_cnt` +1.
- `err_cnt` saturates at 255. It never wraps.
- Reset values: `x` = 0, `y` = 0, `brush` = 0, `newColor` = 0, `ready` = 0, `err_cnt` = 0, FSM = HDR, timer = 0.

## Timing
- Final byte valid in cycle N → `ready` = 1 and new outputs visible in cycle N+1. `ready` = 0 in N+2.
- Back-to-back bytes (`byte_valid` every cycle) are fully supported, with no dead cycles.
- Next B0 may arrive in cycle N+1 while `ready` is high.
- `byte_valid` in the same cycle the timer hits the limit: the byte wins. It is accepted and the timer clears.
- `reset` low mid-packet: all state returns to reset values on the next edge. The partial packet is lost and not counted.
- Outputs hold their last accepted value indefinitely between strobes.

## Configuration
- `PKT_CHECKSUM_EN` defined:
  - 6-byte packet with state CK.
  - B5 must equal B0^B1^B2^B3^B4, else drop, `err_cnt` +1.
  - `ready` follows B5.
- Undefined:
  - 5-byte packet; CK state and XOR accumulator are absent.
  - `ready` follows B4.

## Structure
- Package `paint_pkg` holds:
  - `SYNC_NIBBLE` = 4'hA;
  - `H_ACTIVE`/`V_ACTIVE` defaults;
  - `color_t` (logic [2:0]);
  - decoder state enum `pkt_state_t`.
- One sub-module, `gap_timer`, with inputs `clk`, `reset`, `run`, `clear` and output `expired`.
  - Counter width = $clog2(`TIMEOUT_CYCLES` + 1).

## Test plan
- Valid packet A9,01,3F,00,F0 (checksum 67 if enabled) → one `ready` pulse; x = 319, y = 240, brush = 1, newColor = 1; `err_cnt` = 0.
- Junk 00,55 then valid packet → `err_cnt` = 2, then one correct `ready`.
- x = 640 (B1 = 02, B2 = 80), y = 10 → no `ready`, outputs unchanged, `err_cnt` +1.
- Send A5,00, then idle `TIMEOUT_CYCLES` cycles, then a full valid packet → `err_cnt` +1; second packet accepted.
  - Also send a byte exactly at the limit → it is accepted.
- Two packets back-to-back with `byte_valid` every cycle → two `ready` pulses exactly 5 (or 6) cycles apart.
- `reset` low after B2, and separately 300 bad headers → outputs and `err_cnt` return to 0; counter then saturates at 255.

Source files
------------

// File: rtl/paint_pkg.sv
// rtl/paint_pkg.sv - shared types and defaults for the paint packet decoder
package paint_pkg;

  localparam logic [3:0] SYNC_NIBBLE        = 4'hA;
  localparam int         DEF_H_ACTIVE       = 640;
  localparam int         DEF_V_ACTIVE       = 480;
  localparam int         DEF_TIMEOUT_CYCLES = 25175;

  typedef logic [2:0] color_t;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_XH,
    ST_XL,
    ST_YH,
    ST_YL,
    ST_CK
  } pkt_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/paint_packet_decoder_gap_timer.sv
// rtl/paint_packet_decoder_gap_timer.sv - inter-byte gap timer for the paint packet decoder
module gap_timer
  import paint_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic expired
);

  localparam int            CW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  // count holds (cycles since the last accepted byte) - 1, so expiry lands
  // exactly TIMEOUT_CYCLES cycles after that byte
  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clear || !run) begin
      count <= '0;
    end else if (count != LIMIT) begin
      count <= count + CW'(1);
    end
  end

  assign expired = run && (count == LIMIT);

endmodule

// File: rtl/paint_packet_decoder.sv
// rtl/paint_packet_decoder.sv - SPI byte stream to paint command decoder (option: PKT_CHECKSUM_EN)
module paint_packet_decoder
  import paint_pkg::*;
#(
  parameter int H_ACTIVE       = DEF_H_ACTIVE,
  parameter int V_ACTIVE       = DEF_V_ACTIVE,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       brush,
  output color_t     newColor,
  output logic       ready,
  output logic [7:0] err_cnt
);

  localparam logic [10:0] X_LIMIT = 11'(H_ACTIVE);
  localparam logic [10:0] Y_LIMIT = 11'(V_ACTIVE);

  pkt_state_t state, state_next;

  logic       timer_expired;
  logic       hdr_ok;
  logic       rsv_ok;
  logic       accept_byte;
  logic       final_byte;
  logic       pkt_good;
  logic       err_inc;
  logic [9:0] y_final;

  logic       brush_s;
  color_t     color_s;
  logic [9:0] x_s;
  logic [1:0] y_hi_s;
  logic       rsv_bad_s;
`ifdef PKT_CHECKSUM_EN
  logic [9:0] y_s;
  logic [7:0] csum_s;
`endif

  assign hdr_ok = (byte_data[7:4] == SYNC_NIBBLE);
  assign rsv_ok = (byte_data[7:2] == 6'd0);

  gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk    (clk),
    .reset  (reset),
    .run    (state != ST_HDR),
    .clear  (accept_byte),
    .expired(timer_expired)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_HDR;
    end else begin
      state <= state_next;
    end
  end

  // A byte arriving in the expiry cycle takes priority over the abort
  always_comb begin
    state_next = state;
    if (byte_valid) begin
      case (state)
        ST_HDR:  state_next = hdr_ok ? ST_XH : ST_HDR;
        ST_XH:   state_next = ST_XL;
        ST_XL:   state_next = ST_YH;
        ST_YH:   state_next = ST_YL;
`ifdef PKT_CHECKSUM_EN
        ST_YL:   state_next = ST_CK;
        ST_CK:   state_next = ST_HDR;
`else
        ST_YL:   state_next = ST_HDR;
`endif
        default: state_next = ST_HDR;
      endcase
    end else if (timer_expired) begin
      state_next = ST_HDR;
    end
  end

  always_comb begin
    accept_byte = byte_valid && ((state != ST_HDR) || hdr_ok);
`ifdef PKT_CHECKSUM_EN
    final_byte  = byte_valid && (state == ST_CK);
    y_final     = y_s;
    pkt_good    = !rsv_bad_s && ({1'b0, x_s} < X_LIMIT) && ({1'b0, y_s} < Y_LIMIT)
                  && (byte_data == csum_s);
`else
    final_byte  = byte_valid && (state == ST_YL);
    y_final     = {y_hi_s, byte_data};
    pkt_good    = !rsv_bad_s && ({1'b0, x_s} < X_LIMIT) && ({1'b0, y_final} < Y_LIMIT);
`endif
    err_inc     = (byte_valid && (state == ST_HDR) && !hdr_ok)
                || (final_byte && !pkt_good)
                || (!byte_valid && timer_expired);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      brush_s   <= 1'b0;
      color_s   <= '0;
      x_s       <= '0;
      y_hi_s    <= '0;
      rsv_bad_s <= 1'b0;
`ifdef PKT_CHECKSUM_EN
      y_s       <= '0;
      csum_s    <= '0;
`endif
    end else if (byte_valid) begin
      case (state)
        ST_HDR: begin
          brush_s   <= byte_data[3];
          color_s   <= byte_data[2:0];
          rsv_bad_s <= 1'b0;
        end
        ST_XH: begin
          x_s[9:8]  <= byte_data[1:0];
          rsv_bad_s <= !rsv_ok;
        end
        ST_XL: x_s[7:0] <= byte_data;
        ST_YH: begin
          y_hi_s    <= byte_data[1:0];
          rsv_bad_s <= rsv_bad_s || !rsv_ok;
        end
`ifdef PKT_CHECKSUM_EN
        ST_YL: y_s <= {y_hi_s, byte_data};
`endif
        default: ;
      endcase
`ifdef PKT_CHECKSUM_EN
      csum_s <= (state == ST_HDR) ? byte_data : (csum_s ^ byte_data);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      x        <= '0;
      y        <= '0;
      brush    <= 1'b0;
      newColor <= '0;
      ready    <= 1'b0;
      err_cnt  <= '0;
    end else begin
      ready <= final_byte && pkt_good;
      if (final_byte && pkt_good) begin
        x        <= x_s;
        y        <= y_final;
        brush    <= brush_s;
        newColor <= color_s;
      end
      if (err_inc) begin
        err_cnt <= sat_inc8(err_cnt);
      end
    end
  end

endmodule
